// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port register file.
package rf_pkg;

  localparam int RF_DATA_W    = 32;
  localparam int RF_ADDR_W    = 5;
  localparam int RF_ZERO_ADDR = 0;

  typedef logic [RF_DATA_W-1:0] rf_data_t;
  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by a reservation,
// cleared by any write to that register, with the reservation taking priority.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;
  logic [DEPTH-1:0] clr_mask;
  logic [DEPTH-1:0] set_mask;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) begin
        clr_mask[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
    if (rsv_en) begin
      set_mask[rsv_addr] = 1'b1;
    end
    // Set is applied after clear so a same-cycle reservation keeps the bit busy.
    busy_next = (busy_reg & ~clr_mask) | set_mask;
    busy_next[RF_ZERO_ADDR] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd_busy
      assign rd_busy[gi] = busy_reg[rd_addr[gi*ADDR_W +: ADDR_W]];
    end
  endgenerate

  assign busy_vec = busy_reg;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with hardwired-zero r0, highest-port-wins writes and
// a RAW scoreboard. Define RF_BYPASS_EN to forward same-cycle writes to reads.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(RF_ZERO_ADDR);

  logic [ADDR_W-1:0] wr_addr_a [NUM_WR];
  logic [DATA_W-1:0] wr_data_a [NUM_WR];
  logic [DATA_W-1:0] regs_reg  [DEPTH];
  logic [DATA_W-1:0] regs_next [DEPTH];
  logic [NUM_RD-1:0] sb_rd_busy;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wr_unpack
      assign wr_addr_a[gi] = wr_addr[gi*ADDR_W +: ADDR_W];
      assign wr_data_a[gi] = wr_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Ports are applied in ascending order, so the highest enabled port wins.
  always_comb begin
    regs_next = regs_reg;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (wr_addr_a[j] != ZERO_A)) begin
        regs_next[wr_addr_a[j]] = wr_data_a[j];
      end
    end
    regs_next[RF_ZERO_ADDR] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_reg[k] <= '0;
      end
    end else begin
      regs_reg <= regs_next;
    end
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (sb_rd_busy),
    .busy_vec (busy_vec)
  );

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] stored;

      assign addr   = rd_addr[gi*ADDR_W +: ADDR_W];
      assign stored = (addr == ZERO_A) ? '0 : regs_reg[addr];

`ifdef RF_BYPASS_EN
      logic              fwd_hit;
      logic [DATA_W-1:0] fwd_data;

      // A write in a reset cycle never lands, so it is not forwarded either.
      always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = stored;
        for (int j = 0; j < NUM_WR; j++) begin
          if (!reset && wr_en[j] && (wr_addr_a[j] == addr) && (addr != ZERO_A)) begin
            fwd_hit  = 1'b1;
            fwd_data = wr_data_a[j];
          end
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = fwd_data;
      assign rd_busy[gi] = fwd_hit ? (rsv_en && (rsv_addr == addr)) : sb_rd_busy[gi];
`else
      assign rd_data[gi*DATA_W +: DATA_W] = stored;
      assign rd_busy[gi] = sb_rd_busy[gi];
`endif
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp; expectations follow RF_BYPASS_EN when defined.
module tb_reg_file_mp;
  import rf_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic [DEPTH-1:0]  busy_vec;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural register contents and pending-producer flags.
  logic [DW-1:0] m_regs [DEPTH];
  logic          m_busy [DEPTH];

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_vec (busy_vec)
  );

  task automatic idle();
    reset    = 1'b0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input int p, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[p]            = en;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] rd_port(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  // Apply this cycle's inputs to the model: what the register file holds after the edge.
  task automatic model_commit();
    rf_addr_t a;
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        m_regs[k] = '0;
        m_busy[k] = 1'b0;
      end
    end else begin
      for (int j = 0; j < NW; j++) begin
        a = wr_addr[j*AW +: AW];
        if (wr_en[j] && a != 0) begin
          m_regs[a] = wr_data[j*DW +: DW];
          m_busy[a] = 1'b0;
        end
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  // What a read port should show this cycle, given the model and the live inputs.
  task automatic exp_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic b);
    d = (a == 0) ? '0 : m_regs[a];
    b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef RF_BYPASS_EN
    if (!reset && a != 0) begin
      for (int j = NW - 1; j >= 0; j--) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
          d = wr_data[j*DW +: DW];
          b = rsv_en && (rsv_addr == a);
          break;
        end
      end
    end
`endif
  endtask

  task automatic test_reset();
    idle();
    rd_addr = '0;
    reset = 1'b1;
    tick();
    idle();
    set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
    rsv_en = 1'b1; rsv_addr = 5'd5;
    tick();
    idle();
    set_rd(0, 5'd5);
    @(negedge clk);
    n_checks++;
    if (rd_port(0) !== 32'hDEADBEEF || rd_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL preload: rd_data=%h busy=%b, expected deadbeef busy=1", rd_port(0), rd_busy[0]);
    end
    reset = 1'b1;
    set_wr(0, 1'b1, 5'd5, 32'h12345678);
    rsv_en = 1'b1; rsv_addr = 5'd5;
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (rd_port(0) !== 32'h0 || rd_busy[0] !== 1'b0 || busy_vec !== '0) begin
      n_fail++;
      $display("FAIL reset_override: rd_data=%h busy=%b busy_vec=%h, expected 0/0/0", rd_port(0), rd_busy[0], busy_vec);
    end
    $display("txn reset: reg5 after reset rd_data=%h busy_vec=%h", rd_port(0), busy_vec);
    for (int a = 0; a < DEPTH; a += 2) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(a + 1));
      @(negedge clk);
      n_checks++;
      if (rd_port(0) !== 32'h0 || rd_port(1) !== 32'h0 || rd_busy !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_sweep r%0d/r%0d: data=%h/%h busy=%b, expected zeros", a, a + 1, rd_port(0), rd_port(1), rd_busy);
      end
      tick();
    end
  endtask

  task automatic test_conflict();
    idle();
    set_wr(0, 1'b1, 5'd7, 32'h11111111);
    set_wr(1, 1'b1, 5'd7, 32'h22222222);
    tick();
    idle();
    set_wr(0, 1'b1, 5'd8, 32'h88888888);
    set_wr(1, 1'b1, 5'd9, 32'h99999999);
    set_rd(0, 5'd7);
    @(negedge clk);
    n_checks++;
    if (rd_port(0) !== 32'h22222222) begin
      n_fail++;
      $display("FAIL conflict_r7: got %h, expected 22222222", rd_port(0));
    end
    $display("txn conflict: r7=%h", rd_port(0));
    tick();
    idle();
    set_rd(0, 5'd8);
    set_rd(1, 5'd9);
    @(negedge clk);
    n_checks++;
    if (rd_port(0) !== 32'h88888888 || rd_port(1) !== 32'h99999999) begin
      n_fail++;
      $display("FAIL dual_commit: got %h/%h, expected 88888888/99999999", rd_port(0), rd_port(1));
    end
    $display("txn dual_commit: r8=%h r9=%h", rd_port(0), rd_port(1));
    tick();
  endtask

  task automatic test_zero();
    idle();
    set_wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
    set_wr(1, 1'b1, 5'd0, 32'hFFFFFFFF);
    rsv_en = 1'b1; rsv_addr = 5'd0;
    set_rd(0, 5'd0);
    set_rd(1, 5'd0);
    @(negedge clk);
    n_checks++;
    if (rd_port(0) !== 32'h0 || rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_same_cycle: data=%h busy=%b, expected 0/0", rd_port(0), rd_busy[0]);
    end
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (rd_port(1) !== 32'h0 || rd_busy[1] !== 1'b0 || busy_vec[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_after: data=%h busy=%b busy_vec0=%b, expected 0/0/0", rd_port(1), rd_busy[1], busy_vec[0]);
    end
    $display("txn zero: r0=%h busy=%b", rd_port(1), rd_busy[1]);
    tick();
  endtask

  task automatic test_scoreboard();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd3;
    set_rd(0, 5'd3);
    @(negedge clk);
    n_checks++;
    if (rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_before: busy=%b, expected 0", rd_busy[0]);
    end
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (rd_busy[0] !== 1'b1 || busy_vec[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_reserved: busy=%b busy_vec3=%b, expected 1/1", rd_busy[0], busy_vec[3]);
    end
    tick();
    set_wr(0, 1'b1, 5'd3, 32'hA5A5A5A5);
    @(negedge clk);
    n_checks++;
`ifdef RF_BYPASS_EN
    if (rd_port(0) !== 32'hA5A5A5A5 || rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_write_cycle: data=%h busy=%b, expected a5a5a5a5/0", rd_port(0), rd_busy[0]);
    end
`else
    if (rd_port(0) !== 32'h0 || rd_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_write_cycle: data=%h busy=%b, expected 0/1", rd_port(0), rd_busy[0]);
    end
`endif
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (rd_port(0) !== 32'hA5A5A5A5 || rd_busy[0] !== 1'b0 || busy_vec[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_cleared: data=%h busy=%b, expected a5a5a5a5/0", rd_port(0), rd_busy[0]);
    end
    $display("txn scoreboard: r3=%h busy=%b", rd_port(0), rd_busy[0]);
    set_wr(1, 1'b1, 5'd3, 32'h00000033);
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (rd_port(0) !== 32'h00000033 || rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_idle_write: data=%h busy=%b, expected 00000033/0", rd_port(0), rd_busy[0]);
    end
    tick();
  endtask

  task automatic test_rsv_write_same();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    set_wr(0, 1'b1, 5'd9, 32'h00001234);
    tick();
    idle();
    set_rd(1, 5'd9);
    @(negedge clk);
    n_checks++;
    if (rd_port(1) !== 32'h00001234 || rd_busy[1] !== 1'b1 || busy_vec[9] !== 1'b1) begin
      n_fail++;
      $display("FAIL rsv_wins: data=%h busy=%b busy_vec9=%b, expected 00001234/1/1", rd_port(1), rd_busy[1], busy_vec[9]);
    end
    $display("txn rsv_write_same: r9=%h busy=%b", rd_port(1), rd_busy[1]);
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    idle();
    set_wr(1, 1'b1, 5'd9, 32'h00005678);
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (rd_busy[1] !== 1'b0 || rd_port(1) !== 32'h00005678) begin
      n_fail++;
      $display("FAIL single_producer: data=%h busy=%b, expected 00005678/0", rd_port(1), rd_busy[1]);
    end
    tick();
  endtask

  task automatic test_bypass();
    idle();
    set_wr(0, 1'b1, 5'd12, 32'h0BADF00D);
    rsv_en = 1'b1; rsv_addr = 5'd12;
    tick();
    idle();
    set_wr(0, 1'b1, 5'd12, 32'h00000BAD);
    set_wr(1, 1'b1, 5'd12, 32'hCAFE0001);
    set_rd(0, 5'd12);
    set_rd(1, 5'd12);
    @(negedge clk);
    n_checks++;
`ifdef RF_BYPASS_EN
    if (rd_port(0) !== 32'hCAFE0001 || rd_port(1) !== 32'hCAFE0001 || rd_busy !== 2'b00) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: data=%h/%h busy=%b, expected cafe0001 busy=00", rd_port(0), rd_port(1), rd_busy);
    end
`else
    if (rd_port(0) !== 32'h0BADF00D || rd_port(1) !== 32'h0BADF00D || rd_busy !== 2'b11) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: data=%h/%h busy=%b, expected 0badf00d busy=11", rd_port(0), rd_port(1), rd_busy);
    end
`endif
    $display("txn bypass: write cycle r12=%h busy=%b", rd_port(0), rd_busy);
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (rd_port(0) !== 32'hCAFE0001 || rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_next_cycle: data=%h busy=%b, expected cafe0001/0", rd_port(0), rd_busy[0]);
    end
    tick();
  endtask

  task automatic test_random();
    logic [DW-1:0]    ed;
    logic             eb;
    logic [DEPTH-1:0] ev;
    for (int t = 0; t < 200; t++) begin
      reset = ($urandom_range(0, 49) == 0);
      for (int j = 0; j < NW; j++) begin
        set_wr(j, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
      end
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = AW'($urandom_range(0, 7));
      for (int p = 0; p < NR; p++) set_rd(p, AW'($urandom_range(0, 7)));
      @(negedge clk);
      for (int p = 0; p < NR; p++) begin
        exp_read(rd_addr[p*AW +: AW], ed, eb);
        n_checks++;
        if (rd_port(p) !== ed || rd_busy[p] !== eb) begin
          n_fail++;
          $display("FAIL random t%0d port%0d r%0d: data=%h busy=%b, expected %h/%b",
                   t, p, rd_addr[p*AW +: AW], rd_port(p), rd_busy[p], ed, eb);
        end
      end
      for (int k = 0; k < DEPTH; k++) ev[k] = m_busy[k];
      n_checks++;
      if (busy_vec !== ev) begin
        n_fail++;
        $display("FAIL random t%0d busy_vec: got %h, expected %h", t, busy_vec, ev);
      end
      $display("txn rand %0d: rst=%b wr_en=%b wa=%h rsv=%b@%0d rd0=%h rd1=%h busy=%b",
               t, reset, wr_en, wr_addr, rsv_en, rsv_addr, rd_port(0), rd_port(1), rd_busy);
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_conflict();
    test_zero();
    test_scoreboard();
    test_rsv_write_same();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file with an integrated pending-write scoreboard for the pipelined CPU datapath.
- Replaces the single-write, two-read register file.
- Generalises width, depth and read/write port count.
- Adds a hardwired-zero register, deterministic write-conflict priority and per-register busy tracking, so the issue stage can stall on RAW hazards.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way
- rd_busy  out  NUM_RD  scoreboard busy bit of each read address
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- rsv_en  in  1  reserve destination (instruction issued, result pending)
- rsv_addr  in  ADDR_W  register to mark busy
- busy_vec  out  2**ADDR_W  full scoreboard, for debug/hazard unit

Behaviour:
- Single clock domain. Reset is synchronous and active-high; both are fixed.
- Reset:
  - All registers clear to 0 and all busy bits clear in the cycle reset is sampled high.
  - Reset overrides any simultaneous wr_en/rsv_en; no write lands in a reset cycle.
  - After reset, every rd_data reads 0 and every rd_busy reads 0.
  - Reset mid-operation discards all pending reservations.
- Reads:
  - Combinational from stored state: rd_data[i] = reg[rd_addr[i]], rd_busy[i] = busy[rd_addr[i]].
  - Zero latency. Any number of ports may read the same address.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and reservations to address 0 are silently dropped.
- Writes:
  - A write with wr_en[j]=1 updates reg[wr_addr[j]] at the rising edge; the new value is visible on reads the following cycle (see option).
  - Ports writing different addresses all commit in the same cycle.
  - Same-address conflict: the highest-index enabled port wins; lower ports are dropped for that address.
- Scoreboard:
  - rsv_en sets busy[rsv_addr] at the edge.
  - Any enabled write to address a clears busy[a] at the edge.
  - A reservation and a write to the same address in the same cycle: busy stays set (reserve wins); the data is still written.
  - Reserving an already-busy register keeps it busy; no counting, single outstanding producer per register.
  - A write to a non-busy register is legal and leaves busy clear.
- Widths: no arithmetic; data passes unmodified. Addresses are always in range because depth = 2**ADDR_W.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined:
  - rd_data[i] forwards the same-cycle wr_data of the highest-index enabled port whose wr_addr matches rd_addr[i] (nonzero address only).
  - rd_busy[i] reads 0 when such a matching write exists and no same-cycle reservation hits that address.
  - Gives write-then-read in one cycle.
- Undefined: reads reflect stored state only; the written value and cleared busy bit appear one cycle after the write.

Decomposition:
- Shared package rf_pkg:
  - default width/depth constants: RF_DATA_W=32, RF_ADDR_W=5
  - RF_ZERO_ADDR=0
  - typedef rf_addr_t, rf_data_t
- One natural sub-module, rf_scoreboard: busy-bit array with set/clear priority logic and the busy_vec/rd_busy lookup.
- Storage, write priority and bypass muxing stay in reg_file_mp.

Test Plan:
- Reset with reg5 preloaded 0xDEADBEEF and busy5 set, wr_en[0]=1 same cycle to reg5 -> next cycle rd_data=0 for reg5, busy_vec=0.
- wr port0 writes 0x11111111 and port1 writes 0x22222222, both to reg7, same cycle -> reg7 reads 0x22222222.
- Write 0xFFFFFFFF to reg0 with rsv_addr=0 -> reg0 reads 0, rd_busy=0, busy_vec[0]=0.
- rsv reg3 at cycle1 -> rd_busy=1 at cycle2; write 0xA5A5A5A5 to reg3 at cycle3 -> rd_busy=0 and data 0xA5A5A5A5 from cycle4.
- rsv reg9 and write 0x1234 to reg9 in the same cycle -> next cycle data 0x1234 and rd_busy=1.
- With RF_BYPASS_EN: read reg12 while port1 writes 0xCAFE0001 to it -> rd_data=0xCAFE0001 and rd_busy=0 in the same cycle. Without the macro -> old value that cycle, new value the next cycle.
